// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRdWait
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int unsigned LAT_CNT_W = 2;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way request picker. Round-robin on a tie, or fixed CPU
// priority when DMEM_ARB_CPU_PRIO_EN is defined.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_served_i,
  output logic       winner_o
);

`ifdef DMEM_ARB_CPU_PRIO_EN
  logic unused_last_served;
  assign unused_last_served = last_served_i;
`endif

  always_comb begin
    winner_o = PORT_CPU;
    unique case (req_i)
      2'b10: winner_o = PORT_LDR;
      2'b11: begin
`ifdef DMEM_ARB_CPU_PRIO_EN
        winner_o = PORT_CPU;
`else
        winner_o = ~last_served_i;
`endif
      end
      default: winner_o = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU (port 0) and a loader (port 1), one transaction
// in flight. Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority. rst_n is active-high.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam bit LatZero = (MEM_LAT == 0);
  // RD_WAIT cycles remaining after the first one; rvalid fires when this hits zero.
  localparam logic [LAT_CNT_W-1:0] LatLoad = LAT_CNT_W'(LatZero ? 0 : MEM_LAT - 1);

  arb_state_e           state_q;
  logic                 winner_q;
  logic [LAT_CNT_W-1:0] cnt_q;
  logic [1:0]           gnt_q;
  logic [1:0]           rvalid_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;

  logic [1:0]        req;
  logic              winner;
  logic              last_served;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req       = {m1_req, m0_req};
  assign sel_we    = winner ? m1_we    : m0_we;
  assign sel_addr  = winner ? m1_addr  : m0_addr;
  assign sel_wdata = winner ? m1_wdata : m0_wdata;

  dmem_arb_pick u_pick (
    .req_i         (req),
    .last_served_i (last_served),
    .winner_o      (winner)
  );

`ifdef DMEM_ARB_CPU_PRIO_EN
  assign last_served = PORT_LDR;
`else
  logic last_served_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      last_served_q <= PORT_LDR;
    end else if (state_q == StIdle && |req) begin
      last_served_q <= winner;
    end
  end

  assign last_served = last_served_q;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StIdle;
      winner_q    <= PORT_CPU;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q          <= StGrant;
            winner_q         <= winner;
            gnt_q[winner]    <= 1'b1;
            mem_we_q         <= sel_we;
            mem_addr_q       <= sel_addr;
            mem_wdata_q      <= sel_wdata;
            rvalid_q[winner] <= !sel_we && LatZero;
          end
        end
        StGrant: begin
          if (!mem_we_q && !LatZero) begin
            state_q            <= StRdWait;
            cnt_q              <= LatLoad;
            rvalid_q[winner_q] <= (MEM_LAT == 1);
          end else begin
            state_q <= StIdle;
          end
        end
        StRdWait: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q              <= cnt_q - 1'b1;
            rvalid_q[winner_q] <= (cnt_q == LAT_CNT_W'(1));
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m0_gnt    = gnt_q[PORT_CPU];
  assign m1_gnt    = gnt_q[PORT_LDR];
  assign m0_rvalid = rvalid_q[PORT_CPU];
  assign m1_rvalid = rvalid_q[PORT_LDR];
  assign m0_rdata  = rvalid_q[PORT_CPU] ? mem_rdata : '0;
  assign m1_rdata  = rvalid_q[PORT_LDR] ? mem_rdata : '0;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
